// File: rtl/pe_pkg.sv
// Shared types and the width-generic saturating adder for the output-stationary PE.
package pe_pkg;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } pe_state_e;

  // Widest accumulator the adder helper supports; narrower widths live in the low bits.
  localparam int unsigned MaxAccW = 64;

  typedef struct packed {
    logic [MaxAccW-1:0] sum;
    logic               ovf;
  } add_res_t;

  function automatic logic [MaxAccW-1:0] acc_umax(input int unsigned w);
    return (w >= MaxAccW) ? '1 : ((MaxAccW'(1) << w) - MaxAccW'(1));
  endfunction

  function automatic logic [MaxAccW-1:0] acc_smax(input int unsigned w);
    return acc_umax(w) >> 1;
  endfunction

  function automatic logic [MaxAccW-1:0] acc_smin(input int unsigned w);
    return MaxAccW'(1) << (w - 1);
  endfunction

  // a and b hold w-bit values in their low bits; the result is w bits wide.
  function automatic add_res_t sat_add(input logic [MaxAccW-1:0] a,
                                       input logic [MaxAccW-1:0] b,
                                       input int unsigned        w,
                                       input logic               is_signed,
                                       input logic               sat);
    logic [MaxAccW:0]   full;
    logic [MaxAccW:0]   carry_sh;
    logic [MaxAccW-1:0] a_sh, b_sh, s_sh;
    add_res_t           r;
    full     = {1'b0, a} + {1'b0, b};
    r.sum    = full[MaxAccW-1:0] & acc_umax(w);
    a_sh     = a >> (w - 1);
    b_sh     = b >> (w - 1);
    s_sh     = r.sum >> (w - 1);
    carry_sh = full >> w;
    if (is_signed) begin
      r.ovf = (a_sh[0] == b_sh[0]) && (s_sh[0] != a_sh[0]);
      if (sat && r.ovf) r.sum = a_sh[0] ? acc_smin(w) : acc_smax(w);
    end else begin
      r.ovf = carry_sh[0];
      if (sat && r.ovf) r.sum = acc_umax(w);
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_mac_os_mac_unit.sv
// Combinational multiply-accumulate datapath: full product, extension, wrap/saturate add.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 32,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [ACC_W-1:0]  acc_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  logic [ACC_W-1:0]           prod_ext;
  add_res_t                   res;
  logic                       unused_hi;

  always_comb begin
    prod_s = $signed({{DATA_W{a_i[DATA_W-1]}}, a_i}) * $signed({{DATA_W{b_i[DATA_W-1]}}, b_i});
    prod_u = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};
    if (SIGNED) prod_ext = ACC_W'(prod_s);
    else        prod_ext = ACC_W'(prod_u);
    res   = sat_add(MaxAccW'(acc_i), MaxAccW'(prod_ext), ACC_W, SIGNED, SATURATE);
    sum_o = res.sum[ACC_W-1:0];
    ovf_o = res.ovf;
  end

  assign unused_hi = ^res.sum;

endmodule

// File: rtl/pe_mac_os.sv
// Output-stationary systolic PE: operand forwarding, gated MAC, and a column drain chain.
module pe_mac_os
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 32,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] left_in,
  input  logic              left_valid,
  input  logic [DATA_W-1:0] up_in,
  input  logic              up_valid,
  output logic [DATA_W-1:0] right_out,
  output logic              right_valid,
  output logic [DATA_W-1:0] down_out,
  output logic              down_valid,
  input  logic              drain,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_valid_in,
  output logic [ACC_W-1:0]  result_out,
  output logic              result_valid,
  output logic              sat_flag,
  output logic [CNT_W-1:0]  mac_count
);

  pe_state_e         state_q, state_d;
  logic [DATA_W-1:0] right_q, right_d, down_q, down_d;
  logic              right_v_q, down_v_q;
  logic [ACC_W-1:0]  acc_q, acc_d, result_q, result_d;
  logic              result_v_q, result_v_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  mac_sum;
  logic              mac_ovf;
  logic              mac_en;

  pe_mac_unit #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_mac (
    .a_i  (left_in),
    .b_i  (up_in),
    .acc_i(acc_q),
    .sum_o(mac_sum),
    .ovf_o(mac_ovf)
  );

  always_comb begin
    right_d    = left_valid ? left_in : '0;
    down_d     = up_valid ? up_in : '0;
    state_d    = state_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    result_v_d = 1'b0;
    // Leaving DRAIN (drain=0) is a normal accumulate cycle, so the MAC is gated on drain only.
    mac_en     = left_valid && up_valid && !drain;

    if (clear) begin
      acc_d = '0;
      sat_d = 1'b0;
      cnt_d = '0;
    end else if (mac_en) begin
      acc_d = mac_sum;
      sat_d = sat_q | mac_ovf;
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_ACC: begin
        if (drain) begin
          result_d   = acc_q;
          result_v_d = 1'b1;
          acc_d      = '0;
          sat_d      = 1'b0;
          cnt_d      = '0;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain) begin
          result_d   = drain_in;
          result_v_d = drain_valid_in;
        end else begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACC;
      right_q    <= '0;
      right_v_q  <= 1'b0;
      down_q     <= '0;
      down_v_q   <= 1'b0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      result_v_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      right_q    <= right_d;
      right_v_q  <= left_valid;
      down_q     <= down_d;
      down_v_q   <= up_valid;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      result_v_q <= result_v_d;
    end
  end

  assign right_out    = right_q;
  assign right_valid  = right_v_q;
  assign down_out     = down_q;
  assign down_valid   = down_v_q;
  assign result_out   = result_q;
  assign result_valid = result_v_q;
  assign sat_flag     = sat_q;
  assign mac_count    = cnt_q;

endmodule
